// File: rtl/ex_divider_if.sv
// Request/response bundle between the OP/EX stage logic and the EX-stage divider.
// The master drives the operands and controls; the slave returns status and result.
`timescale 1ns/1ps
interface ex_divider_if;
    logic        s_start_i;
    logic        s_flush_i;
    logic [1:0]  s_f_i;
    logic [31:0] s_op1_i;
    logic [31:0] s_op2_i;
    logic        s_busy_o;
    logic        s_done_o;
    logic [31:0] s_result_o;

    modport master (
        output s_start_i, s_flush_i, s_f_i, s_op1_i, s_op2_i,
        input  s_busy_o, s_done_o, s_result_o
    );

    modport slave (
        input  s_start_i, s_flush_i, s_f_i, s_op1_i, s_op2_i,
        output s_busy_o, s_done_o, s_result_o
    );
endinterface

// File: rtl/ex_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, resolving UNROLL quotient
// bits per cycle. It holds EX busy while iterating and pulses done with the result.
`timescale 1ns/1ps
module ex_divider #(
    parameter int unsigned UNROLL    = 1,
    parameter bit          FAST_PATH = 1'b1
) (
    input  logic      s_clk_i,
    input  logic      s_resetn_i,
    ex_divider_if.slave bus
);
    localparam int unsigned ITER  = 32 / UNROLL;
    localparam int unsigned CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        rem_q, quo_q, div_q, result_q;
    logic               qsign_q, rsign_q;
    logic [1:0]         f_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               is_signed, div_zero, overflow, special;
    logic [31:0]        op1_abs, op2_abs, fast_res;
    logic [31:0]        rem_nx, quo_nx, q_fix, r_fix, fix_res;
    logic [32:0]        trial;

    assign is_signed = ~bus.s_f_i[0];
    assign div_zero  = (bus.s_op2_i == 32'h0);
    assign overflow  = is_signed && (bus.s_op1_i == 32'h8000_0000)
                       && (bus.s_op2_i == 32'hFFFF_FFFF);
    assign special   = FAST_PATH && (div_zero || overflow);
    assign op1_abs   = (is_signed && bus.s_op1_i[31]) ? -bus.s_op1_i : bus.s_op1_i;
    assign op2_abs   = (is_signed && bus.s_op2_i[31]) ? -bus.s_op2_i : bus.s_op2_i;

    always_comb begin
        if (div_zero) fast_res = bus.s_f_i[1] ? bus.s_op1_i : 32'hFFFF_FFFF;
        else          fast_res = bus.s_f_i[1] ? 32'h0 : 32'h8000_0000;
    end

    // State register
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) state_q <= StIdle;
        else             state_q <= state_d;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        if (bus.s_flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (bus.s_start_i) state_d = special ? StDone : StCalc;
                StCalc:  if (cnt_q == '0) state_d = StFix;
                StFix:   state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.s_busy_o   = (state_q == StCalc) || (state_q == StFix);
        bus.s_done_o   = (state_q == StDone);
        bus.s_result_o = result_q;
    end

    // UNROLL restoring steps; a set trial[32] means the subtraction went negative
    always_comb begin
        rem_nx = rem_q;
        quo_nx = quo_q;
        trial  = '0;
        for (int i = 0; i < int'(UNROLL); i++) begin
            trial = {rem_nx, quo_nx[31]} - {1'b0, div_q};
            if (!trial[32]) rem_nx = trial[31:0];
            else            rem_nx = {rem_nx[30:0], quo_nx[31]};
            quo_nx = {quo_nx[30:0], ~trial[32]};
        end
    end

    always_comb begin
        q_fix   = qsign_q ? -quo_q : quo_q;
        r_fix   = rsign_q ? -rem_q : rem_q;
        fix_res = f_q[1] ? r_fix : q_fix;
    end

    // Datapath; the quotient sign is dropped for divide-by-zero so the all-ones result survives
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            result_q <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            f_q      <= '0;
            cnt_q    <= '0;
        end else if (!bus.s_flush_i) begin
            case (state_q)
                StIdle: begin
                    if (bus.s_start_i) begin
                        rem_q   <= '0;
                        quo_q   <= op1_abs;
                        div_q   <= op2_abs;
                        qsign_q <= is_signed && (bus.s_op1_i[31] ^ bus.s_op2_i[31])
                                   && !div_zero;
                        rsign_q <= is_signed && bus.s_op1_i[31];
                        f_q     <= bus.s_f_i;
                        cnt_q   <= CNT_W'(ITER - 1);
                        if (special) result_q <= fast_res;
                    end
                end
                StCalc: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                StFix:   result_q <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_divider.sv
// Directed bench for ex_divider: three instances (UNROLL=1 fast, UNROLL=1 no fast path,
// UNROLL=4 fast) sharing clock, reset, operands and flush, each with its own start.
`timescale 1ns/1ps
module tb_ex_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush;
    logic [1:0]  f;
    logic [31:0] op1, op2;
    logic [2:0]  start;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ex_divider_if bus1();
    ex_divider_if bus0();
    ex_divider_if bus4();

    assign bus1.s_start_i = start[0];
    assign bus0.s_start_i = start[1];
    assign bus4.s_start_i = start[2];
    assign bus1.s_flush_i = flush;
    assign bus0.s_flush_i = flush;
    assign bus4.s_flush_i = flush;
    assign bus1.s_f_i = f;
    assign bus0.s_f_i = f;
    assign bus4.s_f_i = f;
    assign bus1.s_op1_i = op1;
    assign bus0.s_op1_i = op1;
    assign bus4.s_op1_i = op1;
    assign bus1.s_op2_i = op2;
    assign bus0.s_op2_i = op2;
    assign bus4.s_op2_i = op2;

    ex_divider #(.UNROLL(1), .FAST_PATH(1'b1)) u_div1 (
        .s_clk_i(clk), .s_resetn_i(rst_n), .bus(bus1));
    ex_divider #(.UNROLL(1), .FAST_PATH(1'b0)) u_div0 (
        .s_clk_i(clk), .s_resetn_i(rst_n), .bus(bus0));
    ex_divider #(.UNROLL(4), .FAST_PATH(1'b1)) u_div4 (
        .s_clk_i(clk), .s_resetn_i(rst_n), .bus(bus4));

    // index 0: UNROLL=1 fast, 1: UNROLL=1 no fast path, 2: UNROLL=4 fast
    logic [2:0]  busy_w, done_w;
    logic [31:0] res_w [3];
    assign busy_w   = {bus4.s_busy_o, bus0.s_busy_o, bus1.s_busy_o};
    assign done_w   = {bus4.s_done_o, bus0.s_done_o, bus1.s_done_o};
    assign res_w[0] = bus1.s_result_o;
    assign res_w[1] = bus0.s_result_o;
    assign res_w[2] = bus4.s_result_o;

    // Start pulse in the current cycle T; returns just after the edge into T+1 with the
    // operands scrambled so only latched copies can produce the right answer.
    task automatic issue(input int w, input logic [1:0] fv, input logic [31:0] a,
                         input logic [31:0] b);
        f = fv; op1 = a; op2 = b; start[w] = 1'b1;
        @(posedge clk); #1;
        start[w] = 1'b0; op1 = ~a; op2 = b ^ 32'h5A5A_0001; f = ~fv;
    endtask

    // lat = n such that done is seen in cycle T+n (0 if never within 60 cycles)
    task automatic wait_done(input int w, output int lat, output logic [31:0] res,
                             output int nbusy, output logic busy_at);
        lat = 0; res = '0; nbusy = 0; busy_at = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done_w[w]) begin
                lat = n; res = res_w[w]; busy_at = busy_w[w];
                break;
            end
            if (busy_w[w]) nbusy++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        for (int w = 0; w < 3; w++) begin
            n_checks++;
            if (busy_w[w] !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", w, busy_w[w]);
            end
            n_checks++;
            if (done_w[w] !== 1'b0) begin
                n_fail++; $display("FAIL reset_done[%0d] got %b want 0", w, done_w[w]);
            end
            n_checks++;
            if (res_w[w] !== 32'h0) begin
                n_fail++; $display("FAIL reset_result[%0d] got %h want 0", w, res_w[w]);
            end
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int lat, nb; logic [31:0] res; logic ba;
        issue(0, 2'b01, 32'd100, 32'd7);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (lat !== 34) begin n_fail++; $display("FAIL divu_lat got %0d want 34", lat); end
        n_checks++;
        if (res !== 32'd14) begin n_fail++; $display("FAIL divu_res got %h want 0000000e", res); end
        n_checks++;
        if (nb !== 33) begin n_fail++; $display("FAIL divu_busy_cycles got %0d want 33", nb); end
        n_checks++;
        if (ba !== 1'b0) begin n_fail++; $display("FAIL divu_busy_at_done got %b want 0", ba); end
        issue(0, 2'b11, 32'd100, 32'd7);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (lat !== 34) begin n_fail++; $display("FAIL remu_b2b_lat got %0d want 34", lat); end
        n_checks++;
        if (res !== 32'd2) begin n_fail++; $display("FAIL remu_res got %h want 00000002", res); end
        issue(2, 2'b01, 32'hFFFF_FFFF, 32'd3);
        wait_done(2, lat, res, nb, ba);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL u4_divu_lat got %0d want 10", lat); end
        n_checks++;
        if (res !== 32'h5555_5555) begin
            n_fail++; $display("FAIL u4_divu_res got %h want 55555555", res);
        end
    endtask

    task automatic test_signed();
        int lat, nb; logic [31:0] res; logic ba;
        issue(0, 2'b00, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_res got %h want fffffffd", res); end
        issue(0, 2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg_res got %h want ffffffff", res); end
        issue(0, 2'b00, 32'd7, 32'hFFFF_FFFE);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negdiv_res got %h want fffffffd", res); end
        issue(0, 2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (res !== 32'd1) begin n_fail++; $display("FAIL rem_negdiv_res got %h want 00000001", res); end
        issue(2, 2'b10, 32'hFFFF_FF9C, 32'd7);
        wait_done(2, lat, res, nb, ba);
        n_checks++;
        if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL u4_rem_res got %h want fffffffe", res); end
    endtask

    task automatic test_div_zero();
        int lat, nb; logic [31:0] res; logic ba;
        issue(0, 2'b01, 32'd5, 32'd0);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL divu_zero_lat got %0d want 1", lat); end
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero_res got %h want ffffffff", res); end
        issue(0, 2'b10, 32'd5, 32'd0);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (res !== 32'd5) begin n_fail++; $display("FAIL rem_zero_res got %h want 00000005", res); end
        issue(0, 2'b00, 32'hFFFF_FFFB, 32'd0);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_negzero_res got %h want ffffffff", res); end
        issue(1, 2'b00, 32'hFFFF_FFFB, 32'd0);
        wait_done(1, lat, res, nb, ba);
        n_checks++;
        if (lat !== 34) begin n_fail++; $display("FAIL slow_div_zero_lat got %0d want 34", lat); end
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL slow_div_zero_res got %h want ffffffff", res); end
        issue(1, 2'b10, 32'hFFFF_FFFB, 32'd0);
        wait_done(1, lat, res, nb, ba);
        n_checks++;
        if (res !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL slow_rem_zero_res got %h want fffffffb", res); end
    endtask

    task automatic test_overflow();
        int lat, nb; logic [31:0] res; logic ba;
        issue(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL ovf_div_lat got %0d want 1", lat); end
        n_checks++;
        if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_div_res got %h want 80000000", res); end
        issue(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (res !== 32'h0) begin n_fail++; $display("FAIL ovf_rem_res got %h want 00000000", res); end
        issue(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat, res, nb, ba);
        n_checks++;
        if (lat !== 34) begin n_fail++; $display("FAIL slow_ovf_lat got %0d want 34", lat); end
        n_checks++;
        if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL slow_ovf_div_res got %h want 80000000", res); end
        issue(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat, res, nb, ba);
        n_checks++;
        if (res !== 32'h0) begin n_fail++; $display("FAIL slow_ovf_rem_res got %h want 00000000", res); end
        issue(0, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (lat !== 34) begin n_fail++; $display("FAIL divu_big_lat got %0d want 34", lat); end
        n_checks++;
        if (res !== 32'h0) begin n_fail++; $display("FAIL divu_big_res got %h want 00000000", res); end
    endtask

    task automatic test_start_ignored();
        int lat, nb; logic [31:0] res; logic ba;
        issue(0, 2'b01, 32'd100, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        f = 2'b00; op1 = 32'd1000; op2 = 32'd3; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (lat !== 29) begin n_fail++; $display("FAIL busy_start_lat got %0d want 29", lat); end
        n_checks++;
        if (res !== 32'd14) begin n_fail++; $display("FAIL busy_start_res got %h want 0000000e", res); end
    endtask

    task automatic test_flush();
        int lat, nb; logic [31:0] res; logic ba;
        issue(0, 2'b01, 32'd1000, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy_w[0]); end
        n_checks++;
        if (res_w[0] !== 32'd14) begin n_fail++; $display("FAIL flush_result got %h want 0000000e", res_w[0]); end
        issue(0, 2'b01, 32'd1000, 32'd10);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (lat !== 34) begin n_fail++; $display("FAIL after_flush_lat got %0d want 34", lat); end
        n_checks++;
        if (res !== 32'd100) begin n_fail++; $display("FAIL after_flush_res got %h want 00000064", res); end
        f = 2'b01; op1 = 32'd50; op2 = 32'd5; start[0] = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0; flush = 1'b0;
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (lat !== 0 || nb !== 0) begin
            n_fail++; $display("FAIL start_flush_idle got lat=%0d busy=%0d want 0/0", lat, nb);
        end
        n_checks++;
        if (res_w[0] !== 32'd100) begin n_fail++; $display("FAIL start_flush_res got %h want 00000064", res_w[0]); end
    endtask

    task automatic test_reset_mid();
        int lat, nb, bad; logic [31:0] res; logic ba;
        issue(0, 2'b01, 32'hFFFF_FFFF, 32'd1);
        repeat (4) begin @(posedge clk); #1; end
        n_checks++;
        if (busy_w[0] !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", busy_w[0]); end
        rst_n = 1'b0; start[0] = 1'b1; f = 2'b01; op1 = 32'd9; op2 = 32'd3;
        #1;
        n_checks++;
        if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_ctrl got %b%b want 00", busy_w[0], done_w[0]);
        end
        n_checks++;
        if (res_w[0] !== 32'h0) begin n_fail++; $display("FAIL mid_reset_result got %h want 0", res_w[0]); end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy_w[0] || done_w[0]) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_start_ignored got %0d active cycles want 0", bad); end
        start[0] = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        issue(0, 2'b01, 32'd9, 32'd3);
        wait_done(0, lat, res, nb, ba);
        n_checks++;
        if (lat !== 34 || res !== 32'd3) begin
            n_fail++; $display("FAIL post_reset_op got lat=%0d res=%h want 34/00000003", lat, res);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        start = '0; flush = 1'b0; f = 2'b00; op1 = '0; op2 = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
